mem_port_arbiter: RTL

Round-robin arbiter that shares one port of the dual-port SRAM wrapper between up to eight requesters (scalar core LSU, vector unit, debug/DMA), each using the same req/gnt/rvalid/err handshake the wrapper exposes. It selects one requester per cycle and forwards its address, write-enable, byte-enables and write data to the memory port. It tracks outstanding transactions in an ID FIFO so each read data / error response is routed back to the requester that issued it. Two instances drive ports A and B of the wrapper.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arb_id_fifo.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory port arbiter and its ID FIFO.
package mem_arb_pkg;

    localparam int MEM_ARB_MAX_REQ         = 8;
    localparam int MEM_ARB_MAX_OUTSTANDING = 4;

    typedef logic [2:0] arb_id_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Requester-ID FIFO for outstanding memory transactions; head is combinational.
// Push is dropped when full unless a pop happens in the same cycle.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  arb_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output arb_id_t head
);

    localparam logic [1:0] LAST    = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    arb_id_t    mem [MEM_ARB_MAX_OUTSTANDING];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 3'd0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MEM_ARB_MAX_OUTSTANDING; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (do_pop) rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
            if (do_push && !do_pop)      count <= count + 3'd1;
            else if (!do_push && do_pop) count <= count - 3'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin (or fixed priority with MEM_ARB_FIXED_PRIO_EN) share of one SRAM port.
// Zero-latency grant; responses routed by ID FIFO; requests held off while the FIFO is full.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    s_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    s_addr,
    input  logic [NUM_REQ-1:0]                    s_we,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  s_be,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    s_wdata,
    output logic [NUM_REQ-1:0]                    s_gnt,
    output logic [NUM_REQ-1:0]                    s_rvalid,
    output logic [NUM_REQ-1:0]                    s_err,
    output logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic                                  m_req,
    output logic [ADDR_WIDTH-1:0]                 m_addr,
    output logic                                  m_we,
    output logic [DATA_WIDTH/8-1:0]               m_be,
    output logic [DATA_WIDTH-1:0]                 m_wdata,
    input  logic                                  m_gnt,
    input  logic                                  m_rvalid,
    input  logic                                  m_err,
    input  logic [DATA_WIDTH-1:0]                 m_rdata,
    output logic                                  protocol_err
);

    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic [NUM_REQ-1:0] eligible;
    arb_id_t            win;
    arb_id_t            head;

    // A pop this cycle frees a slot, so a full FIFO can still accept a grant.
    assign pop      = m_rvalid & ~fifo_empty;
    assign eligible = s_req & {NUM_REQ{~fifo_full | pop}};
    assign m_req    = rst & (|eligible);
    assign push     = m_req & m_gnt;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) win = arb_id_t'(i);
        end
    end
`else
    arb_id_t rr_ptr;

    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && eligible[idx]) begin
                win   = arb_id_t'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (push)
            rr_ptr <= (win == arb_id_t'(NUM_REQ - 1)) ? '0 : win + 3'd1;
    end
`endif

    assign m_addr  = m_req ? s_addr[win]  : '0;
    assign m_we    = m_req ? s_we[win]    : 1'b0;
    assign m_be    = m_req ? s_be[win]    : '0;
    assign m_wdata = m_req ? s_wdata[win] : '0;
    assign s_rdata = m_rdata;

    always_comb begin
        s_gnt    = '0;
        s_rvalid = '0;
        s_err    = '0;
        if (push) s_gnt[win] = 1'b1;
        if (rst && pop) begin
            s_rvalid[head] = 1'b1;
            s_err[head]    = m_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            protocol_err <= 1'b0;
        else if (m_rvalid && fifo_empty)
            protocol_err <= 1'b1;
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (win),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

endmodule
